// File: rtl/ascii_hex_encoder.sv
// Serialises a captured binary word as ASCII hex digits, most significant first,
// with an optional CR/LF terminator, over a valid/ready character stream.
module ascii_hex_encoder #(
  parameter int NIBBLES     = 8,
  parameter int APPEND_CRLF = 1,
  parameter int UPPERCASE   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [4*NIBBLES-1:0] data_i,
  output logic [7:0]           char_o,
  output logic                 char_valid_o,
  input  logic                 char_ready_i,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [2:0] {IDLE, HEX, CR, LF, DONE} state_t;

  state_t               r_state, w_stateNext;
  logic [CW-1:0]        r_cnt, w_cntNext;
  logic [4*NIBBLES-1:0] r_word, w_wordNext;
  logic [7:0]           r_char, w_charNext;
  logic                 r_valid, w_validNext;
  logic                 w_xfer;

  function automatic logic [7:0] hexAscii(input logic [4*NIBBLES-1:0] word,
                                          input logic [CW-1:0] idx);
    logic [4*NIBBLES-1:0] shifted;
    logic [3:0]           nib;
    shifted = word >> {idx, 2'b00};
    nib     = shifted[3:0];
    if (nib < 4'd10)
      hexAscii = 8'h30 + {4'h0, nib};
    else if (UPPERCASE != 0)
      hexAscii = 8'h37 + {4'h0, nib};
    else
      hexAscii = 8'h57 + {4'h0, nib};
  endfunction

  assign w_xfer = r_valid & char_ready_i;

  // The next character is computed here so char_o/char_valid_o leave a register.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_wordNext  = r_word;
    w_charNext  = r_char;
    w_validNext = r_valid;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_wordNext  = data_i;
          w_cntNext   = CW'(NIBBLES - 1);
          w_charNext  = hexAscii(data_i, CW'(NIBBLES - 1));
          w_validNext = 1'b1;
          w_stateNext = HEX;
        end
      end
      HEX: begin
        if (w_xfer) begin
          if (r_cnt != '0) begin
            w_cntNext  = r_cnt - CW'(1);
            w_charNext = hexAscii(r_word, r_cnt - CW'(1));
          end else if (APPEND_CRLF != 0) begin
            w_stateNext = CR;
            w_charNext  = 8'h0D;
          end else begin
            w_stateNext = DONE;
            w_validNext = 1'b0;
          end
        end
      end
      CR: begin
        if (w_xfer) begin
          w_stateNext = LF;
          w_charNext  = 8'h0A;
        end
      end
      LF: begin
        if (w_xfer) begin
          w_stateNext = DONE;
          w_validNext = 1'b0;
        end
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
        w_validNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
      r_char  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_word  <= w_wordNext;
      r_char  <= w_charNext;
      r_valid <= w_validNext;
    end
  end

  assign char_o       = r_char;
  assign char_valid_o = r_valid;
  assign busy_o       = (r_state != IDLE);
  assign done_o       = (r_state == DONE);

endmodule

// File: tb/tb_ascii_hex_encoder.sv
// Drives three encoder configurations (default, lowercase/no-CRLF, 2-digit)
// and checks every transferred character against a string-lookup reference.
module tb_ascii_hex_encoder;

  logic             clk;
  logic             rst_n;
  logic [2:0]       startV;
  logic [2:0]       readyV;
  logic [31:0]      dataV;
  logic [2:0][7:0]  charO;
  logic [2:0]       validO;
  logic [2:0]       busyO;
  logic [2:0]       doneO;

  int          nChecks = 0;
  int          nPass   = 0;
  logic [7:0]  expChars [3][10];
  int          expLen   [3];
  int          expIdx   [3];
  int          cyc      [3];
  logic [7:0]  prevChar [3];
  logic [2:0]  active    = '0;
  logic [2:0]  stalled   = '0;
  logic [2:0]  prevStall = '0;
  logic [2:0]  prevDone  = '0;

  ascii_hex_encoder #(.NIBBLES(8), .APPEND_CRLF(1), .UPPERCASE(1)) dutA (
    .clk(clk), .rst_n(rst_n), .start_i(startV[0]), .data_i(dataV),
    .char_o(charO[0]), .char_valid_o(validO[0]), .char_ready_i(readyV[0]),
    .busy_o(busyO[0]), .done_o(doneO[0]));

  ascii_hex_encoder #(.NIBBLES(8), .APPEND_CRLF(0), .UPPERCASE(0)) dutB (
    .clk(clk), .rst_n(rst_n), .start_i(startV[1]), .data_i(dataV),
    .char_o(charO[1]), .char_valid_o(validO[1]), .char_ready_i(readyV[1]),
    .busy_o(busyO[1]), .done_o(doneO[1]));

  ascii_hex_encoder #(.NIBBLES(2), .APPEND_CRLF(1), .UPPERCASE(1)) dutC (
    .clk(clk), .rst_n(rst_n), .start_i(startV[2]), .data_i(dataV[7:0]),
    .char_o(charO[2]), .char_valid_o(validO[2]), .char_ready_i(readyV[2]),
    .busy_o(busyO[2]), .done_o(doneO[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed === expected)
      nPass++;
    else
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
  endtask

  // Reference frame: the hex text of the word, then CR LF when enabled.
  task automatic loadExpected(input int k, input logic [31:0] d);
    string digits;
    int    n;
    int    nDigits;
    int    nib;
    bit    upper;
    bit    crlf;
    nDigits = (k == 2) ? 2 : 8;
    upper   = (k != 1);
    crlf    = (k != 1);
    digits  = upper ? "0123456789ABCDEF" : "0123456789abcdef";
    n = 0;
    for (int i = nDigits - 1; i >= 0; i--) begin
      nib = int'((d >> (4 * i)) & 32'hF);
      expChars[k][n] = digits[nib];
      n++;
    end
    if (crlf) begin
      expChars[k][n] = 8'h0D;
      expChars[k][n+1] = 8'h0A;
      n += 2;
    end
    expLen[k]  = n;
    expIdx[k]  = 0;
    cyc[k]     = 0;
    active[k]  = 1'b1;
    stalled[k] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      active    = '0;
      prevStall = '0;
      prevDone  = '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("busy%0d", k), 32'(busyO[k]), 32'(validO[k] | doneO[k]));
        if (prevStall[k])
          checkOutput($sformatf("hold%0d", k), 32'({validO[k], charO[k]}), 32'({1'b1, prevChar[k]}));
        if (validO[k] && readyV[k]) begin
          if (active[k] && expIdx[k] < expLen[k])
            checkOutput($sformatf("char%0d[%0d]", k, expIdx[k]), 32'(charO[k]), 32'(expChars[k][expIdx[k]]));
          else
            checkOutput($sformatf("spuriousValid%0d", k), 32'(validO[k]), 32'd0);
          expIdx[k]++;
        end
        prevStall[k] = validO[k] & ~readyV[k];
        prevChar[k]  = charO[k];
        if (prevStall[k]) stalled[k] = 1'b1;
        if (active[k]) cyc[k]++;
        if (doneO[k]) begin
          checkOutput($sformatf("doneActive%0d", k), 32'(active[k]), 32'd1);
          checkOutput($sformatf("doneAllChars%0d", k), 32'(expIdx[k]), 32'(expLen[k]));
          checkOutput($sformatf("donePulse%0d", k), 32'(prevDone[k]), 32'd0);
          if (active[k] && !stalled[k])
            checkOutput($sformatf("doneCycle%0d", k), 32'(cyc[k]), 32'(expLen[k] + 2));
          active[k] = 1'b0;
        end
        prevDone[k] = doneO[k];
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] mask, input logic [31:0] d);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++)
      if (mask[k]) loadExpected(k, d);
    startV = mask;
    dataV  = d;
    @(posedge clk); #1;
    startV = '0;
    dataV  = $urandom;
    checkOutput("latency", 32'(validO & mask), 32'(mask));
  endtask

  task automatic runFrames(input logic [2:0] mask, input bit rnd);
    int n;
    n = 0;
    while ((active & mask) != '0 && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (rnd) begin
        readyV = 3'($urandom);
        startV = 3'($urandom) & active;
        dataV  = $urandom;
      end else begin
        readyV = 3'b111;
      end
    end
    startV = '0;
    readyV = 3'b111;
    checkOutput("frameTimeout", 32'(active & mask), 32'd0);
  endtask

  task automatic waitForChar(input int k, input logic [7:0] ch);
    int n;
    n = 0;
    while (!(validO[k] && charO[k] == ch) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("waitChar", 32'(charO[k]), 32'(ch));
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    startV = '0;
    readyV = 3'b111;
    dataV  = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("rstChar%0d", k), 32'(charO[k]), 32'd0);
      checkOutput($sformatf("rstValid%0d", k), 32'(validO[k]), 32'd0);
      checkOutput($sformatf("rstBusy%0d", k), 32'(busyO[k]), 32'd0);
      checkOutput($sformatf("rstDone%0d", k), 32'(doneO[k]), 32'd0);
    end
    rst_n = 1'b1;

    applyStimulus(3'b001, 32'h1234ABCD);
    runFrames(3'b001, 1'b0);
    applyStimulus(3'b010, 32'hFFFF00A5);
    runFrames(3'b010, 1'b0);
    applyStimulus(3'b100, 32'h0000000F);
    runFrames(3'b100, 1'b0);

    // Backpressure while '3' is on the line
    applyStimulus(3'b001, 32'h1234ABCD);
    waitForChar(0, 8'h33);
    readyV = 3'b000;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("bpHold", 32'({validO[0], charO[0]}), 32'({1'b1, 8'h33}));
    end
    readyV = 3'b111;
    runFrames(3'b001, 1'b0);

    // Start requests during an active frame are ignored
    applyStimulus(3'b001, 32'h1234ABCD);
    repeat (3) @(posedge clk);
    #1;
    startV = 3'b001;
    dataV  = 32'h55555555;
    repeat (2) @(posedge clk);
    #1;
    startV = '0;
    runFrames(3'b001, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("noSecondFrame", 32'({validO[0], busyO[0]}), 32'd0);

    // Start request in the DONE cycle is ignored
    applyStimulus(3'b001, $urandom);
    n = 0;
    while (!doneO[0] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("reachDone", 32'(doneO[0]), 32'd1);
    startV = 3'b001;
    @(posedge clk); #1;
    startV = '0;
    checkOutput("doneStartValid", 32'(validO[0]), 32'd0);
    checkOutput("doneStartBusy", 32'(busyO[0]), 32'd0);
    @(posedge clk); #1;
    checkOutput("doneStartValid2", 32'(validO[0]), 32'd0);

    // Reset mid-frame aborts without a done pulse
    applyStimulus(3'b001, 32'h1234ABCD);
    waitForChar(0, 8'h42);
    rst_n = 1'b0;
    #1;
    checkOutput("abortValid", 32'(validO[0]), 32'd0);
    checkOutput("abortChar", 32'(charO[0]), 32'd0);
    checkOutput("abortBusy", 32'(busyO[0]), 32'd0);
    checkOutput("abortDone", 32'(doneO[0]), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("abortNoDone", 32'({doneO[0], validO[0]}), 32'd0);
    end
    applyStimulus(3'b001, 32'h00000009);
    runFrames(3'b001, 1'b0);

    repeat (25) begin
      applyStimulus(3'($urandom_range(1, 7)), $urandom);
      runFrames(3'b111, 1'b1);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/ascii_hex_encoder.md
ASCII_HEX_ENCODER -- requirements
Module: ascii_hex_encoder

Interface
- REQ-001 SHALL provide parameter NIBBLES, default 8: number of hex digits per word (1..8).
- REQ-002 SHALL provide parameter APPEND_CRLF, default 1: 1 = append CR (0x0D) then LF (0x0A) after the last digit; 0 = no terminator.
- REQ-003 SHALL provide parameter UPPERCASE, default 1: 1 = digits A-F as 0x41-0x46; 0 = digits a-f as 0x61-0x66.
- REQ-004 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
- REQ-005 SHALL provide port rst_n  input  1  reset; asynchronous assertion, active-low.
- REQ-006 SHALL provide port start_i  input  1  request to encode data_i; sampled only in IDLE.
- REQ-007 SHALL provide port data_i  input  4*NIBBLES  word to encode; captured on the accepted start cycle.
- REQ-008 SHALL provide port char_o  output  8  ASCII character toward the UART transmitter.
- REQ-009 SHALL provide port char_valid_o  output  1  char_o holds a valid character.
- REQ-010 SHALL provide port char_ready_i  input  1  sink accepts char_o this cycle.
- REQ-011 SHALL provide port busy_o  output  1  high in every state except IDLE.
- REQ-012 SHALL provide port done_o  output  1  one-cycle pulse after the final character transfer.

Function
- REQ-013 SHALL implement FSM states IDLE, HEX, CR, LF, DONE.
- REQ-014 In IDLE with start_i=1, the block SHALL capture data_i, load the digit counter with NIBBLES-1, and enter HEX on the next edge.
- REQ-015 A transfer SHALL occur only on a cycle where char_valid_o=1 and char_ready_i=1.
- REQ-016 char_valid_o SHALL be 1 in HEX, CR and LF, and 0 in IDLE and DONE.
- REQ-017 char_o and char_valid_o SHALL be registered; char_valid_o rises the cycle after start is accepted (1-cycle latency).
- REQ-018 In HEX, char_o SHALL be the ASCII code of nibble [4*cnt+3:4*cnt] of the captured word, most significant nibble first.
- REQ-019 Digit mapping: 0-9 -> 0x30-0x39; 10-15 -> 0x41-0x46 when UPPERCASE=1, else 0x61-0x66.
- REQ-020 While char_ready_i=0, char_o and char_valid_o SHALL hold unchanged (no drop, no skip).
- REQ-021 On a transfer in HEX with cnt>0, the block SHALL decrement cnt and present the next digit on the following cycle.
- REQ-022 On a transfer in HEX with cnt=0, the block SHALL go to CR when APPEND_CRLF=1, else to DONE.
- REQ-023 CR SHALL present 0x0D and go to LF on transfer; LF SHALL present 0x0A and go to DONE on transfer.
- REQ-024 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
- REQ-025 With char_ready_i held at 1, one character SHALL transfer per cycle: NIBBLES (+2 when APPEND_CRLF=1) consecutive transfers.
- REQ-026 start_i while busy_o=1 SHALL be ignored; the captured word SHALL NOT change mid-frame.
- REQ-027 A start_i in the DONE cycle SHALL be ignored; start is accepted no earlier than the following IDLE cycle.
- REQ-028 Changes on data_i after capture SHALL NOT affect emitted characters.

Reset
- REQ-029 When rst_n=0, the block SHALL asynchronously force state=IDLE, cnt=0, captured word=0, char_o=0x00, char_valid_o=0, busy_o=0 and done_o=0.
- REQ-030 Reset mid-frame SHALL abort the frame with no done_o pulse; the next accepted start SHALL begin from the most significant digit.

Verification
- REQ-031 Defaults with char_ready_i=1: start with data_i=0x1234ABCD -> 0x31,0x32,0x33,0x34,0x41,0x42,0x43,0x44,0x0D,0x0A on 10 consecutive cycles, then done_o high for 1 cycle.
- REQ-032 Backpressure: char_ready_i=0 for 3 cycles while char_o=0x33 -> 0x33 held with valid=1 for all 3 cycles; the frame completes intact.
- REQ-033 UPPERCASE=0, APPEND_CRLF=0: data_i=0xFFFF00A5 -> 0x66,0x66,0x66,0x66,0x30,0x30,0x61,0x35, then done_o; no CR/LF.
- REQ-034 start_i with data_i=0x55555555 during an active 0x1234ABCD frame -> output unchanged, no second frame.
- REQ-035 rst_n pulsed low while 0x42 is presented -> char_valid_o=0 immediately and no done_o pulse; a new start with 0x00000009 -> 0x30 x7, 0x39, 0x0D, 0x0A.
- REQ-036 NIBBLES=2, data_i=0x0F -> 0x30, 0x46, 0x0D, 0x0A, done_o.
